// File: rtl/gpio_wb_if.sv
// Wishbone slave bus bundle for the GPIO block.
// The master drives the request fields; the slave returns read data and the acknowledge.
interface gpio_wb_if;
  logic [1:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/gpio_wb.sv
// Wishbone GPIO with N tristate pins: data/OE/set/clear registers and a 2-flop input synchronizer.
// Every access is acked one cycle after the strobe; the ack flop blocks a second access while it is high.
module gpio_wb #(
  parameter int N = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  gpio_wb_if.slave    wb,
  inout  wire [N-1:0] gpio_io
);

  localparam logic [1:0] ADR_DATA = 2'd0;
  localparam logic [1:0] ADR_OE   = 2'd1;
  localparam logic [1:0] ADR_SET  = 2'd2;
  localparam logic [1:0] ADR_CLR  = 2'd3;

  function automatic logic [31:0] zext(input logic [N-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[N-1:0] = v;
    return r;
  endfunction

  logic [N-1:0] out_q, out_d;
  logic [N-1:0] oe_q, oe_d;
  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;
  logic         ack_q, ack_d;
  logic [31:0]  dat_o_q, dat_o_d;

  logic         access_s;
  logic [31:0]  sel_mask_s;
  logic [N-1:0] wmask_s;
  logic [N-1:0] wdat_s;

  assign access_s   = wb.wb_stb_i & ~ack_q;
  assign sel_mask_s = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                       {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
  assign wmask_s    = sel_mask_s[N-1:0];
  assign wdat_s     = wb.wb_dat_i[N-1:0];

  // Next-state for registers, read data and the ack pulse
  always_comb begin
    out_d   = out_q;
    oe_d    = oe_q;
    dat_o_d = dat_o_q;
    ack_d   = access_s;
    sync1_d = gpio_io;
    sync2_d = sync1_q;
    if (access_s) begin
      if (wb.wb_we_i) begin
        case (wb.wb_adr_i)
          ADR_DATA: out_d = (out_q & ~wmask_s) | (wdat_s & wmask_s);
          ADR_OE:   oe_d  = (oe_q & ~wmask_s) | (wdat_s & wmask_s);
          ADR_SET:  out_d = out_q | (wdat_s & wmask_s);
          ADR_CLR:  out_d = out_q & ~(wdat_s & wmask_s);
          default:  out_d = out_q;
        endcase
      end else begin
        case (wb.wb_adr_i)
          ADR_DATA: dat_o_d = zext(sync2_q);
          ADR_OE:   dat_o_d = zext(oe_q);
          ADR_SET:  dat_o_d = zext(out_q);
          ADR_CLR:  dat_o_d = zext(out_q);
          default:  dat_o_d = 32'd0;
        endcase
      end
    end else begin
      dat_o_d = dat_o_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      out_q   <= '0;
      oe_q    <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      ack_q   <= 1'b0;
      dat_o_q <= 32'd0;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      ack_q   <= ack_d;
      dat_o_q <= dat_o_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_o_q;

  for (genvar i = 0; i < N; i++) begin : g_pad
    assign gpio_io[i] = oe_q[i] ? out_q[i] : 1'bz;
  end

endmodule

// File: tb/tb_gpio_wb.sv
// Directed bench for gpio_wb: read expectations go into a scoreboard queue and are popped on each ack.
module tb_gpio_wb;

  logic        wb_clk_i;
  logic        wb_rst_i;
  wire  [31:0] gpio;
  logic [31:0] tb_en;
  logic [31:0] tb_val;
  logic [31:0] sb[$];
  int          n_pass;
  int          n_total;

  gpio_wb_if bus ();

  gpio_wb #(.N(32)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wb       (bus),
    .gpio_io  (gpio)
  );

  for (genvar i = 0; i < 32; i++) begin : g_drv
    assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(tag, bus.wb_dat_o, e);
    end else begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wb_clk_i);
  endtask

  // One strobe, ack checked right after the access edge and gone one cycle later
  task automatic xfer(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input string tag);
    logic [31:0] prev;
    @(negedge wb_clk_i);
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_stb_i = 1'b1;
    prev = bus.wb_dat_o;
    @(posedge wb_clk_i);
    #1;
    chk({tag, "_ack"}, {31'd0, bus.wb_ack_o}, 32'd1);
    if (!we) sb_check({tag, "_rdata"});
    else chk({tag, "_dat_hold"}, bus.wb_dat_o, prev);
    @(negedge wb_clk_i);
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge wb_clk_i);
    #1;
    chk({tag, "_ack_drop"}, {31'd0, bus.wb_ack_o}, 32'd0);
  endtask

  task automatic rd(input logic [1:0] adr, input logic [31:0] exp, input string tag);
    sb.push_back(exp);
    xfer(1'b0, adr, 32'd0, 4'hF, tag);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    tb_en   = 32'hFFFF_FFFF;
    tb_val  = 32'd0;
    wb_rst_i = 1'b1;
    bus.wb_adr_i = 2'd0;
    bus.wb_dat_i = 32'd0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'h0;
    bus.wb_stb_i = 1'b0;
    #1 wb_rst_i = 1'b0;
    #1;
    chk("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    chk("rst_dat", bus.wb_dat_o, 32'd0);
    idle(3);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    chk("post_rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    chk("post_rst_dat", bus.wb_dat_o, 32'd0);
    rd(2'd1, 32'h0000_0000, "rst_oe");
    rd(2'd2, 32'h0000_0000, "rst_set");

    // Drive low byte
    tb_en = 32'hFFFF_FF00;
    xfer(1'b1, 2'd1, 32'h0000_00FF, 4'hF, "wr_oe_ff");
    xfer(1'b1, 2'd0, 32'h0000_00A5, 4'hF, "wr_data_a5");
    chk("pins_a5", gpio & 32'h0000_00FF, 32'h0000_00A5);
    idle(2);
    rd(2'd0, 32'h0000_00A5, "rd_data_a5");

    // Set / clear
    xfer(1'b1, 2'd2, 32'h0000_000A, 4'hF, "wr_set");
    rd(2'd3, 32'h0000_00AF, "rd_after_set");
    xfer(1'b1, 2'd3, 32'h0000_00A0, 4'hF, "wr_clr");
    rd(2'd2, 32'h0000_000F, "rd_after_clr");
    chk("pins_0f", gpio & 32'h0000_00FF, 32'h0000_000F);

    // Byte selects with all pins driven
    tb_en = 32'd0;
    xfer(1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF, "wr_oe_all");
    xfer(1'b1, 2'd0, 32'h0000_0000, 4'hF, "wr_data_0");
    xfer(1'b1, 2'd0, 32'h1122_3344, 4'b0101, "wr_data_sel5");
    rd(2'd2, 32'h0022_0044, "rd_sel5");
    chk("pins_sel5", gpio, 32'h0022_0044);
    xfer(1'b1, 2'd0, 32'hFFFF_FFFF, 4'b0000, "wr_sel0");
    rd(2'd2, 32'h0022_0044, "rd_sel0");
    rd(2'd1, 32'hFFFF_FFFF, "rd_oe_all");
    xfer(1'b1, 2'd3, 32'hFFFF_FFFF, 4'b0100, "clr_sel2");
    rd(2'd3, 32'h0000_0044, "rd_clr_sel2");
    xfer(1'b1, 2'd2, 32'hFFFF_FFFF, 4'b1000, "set_sel3");
    idle(2);
    rd(2'd0, 32'hFF00_0044, "loopback");

    // Input synchronizer latency
    tb_val = 32'd0;
    tb_en  = 32'hFFFF_FFFF;
    xfer(1'b1, 2'd1, 32'h0000_0000, 4'hF, "wr_oe_0");
    idle(3);
    @(negedge wb_clk_i);
    tb_val = 32'hDEAD_BEEF;
    @(posedge wb_clk_i);
    rd(2'd0, 32'h0000_0000, "sync_k1_old");
    @(negedge wb_clk_i);
    tb_val = 32'h1234_5678;
    @(posedge wb_clk_i);
    @(posedge wb_clk_i);
    rd(2'd0, 32'h1234_5678, "sync_k2_new");

    // Held strobe: ack every second cycle, then reset during an ack
    @(negedge wb_clk_i);
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 2'd0;
    bus.wb_sel_i = 4'hF;
    bus.wb_stb_i = 1'b1;
    repeat (3) sb.push_back(32'h1234_5678);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge wb_clk_i);
      chk($sformatf("held_ack_%0d", i), {31'd0, bus.wb_ack_o}, 32'(i % 2));
      if (bus.wb_ack_o) sb_check($sformatf("held_rd_%0d", i));
    end
    bus.wb_adr_i = 2'd2;
    wb_rst_i = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    chk("rst_mid_dat", bus.wb_dat_o, 32'd0);
    @(posedge wb_clk_i);
    #1;
    chk("rst_hold_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    sb.push_back(32'h0000_0000);
    @(posedge wb_clk_i);
    #1;
    chk("fresh_ack", {31'd0, bus.wb_ack_o}, 32'd1);
    sb_check("fresh_rd");
    @(negedge wb_clk_i);
    bus.wb_stb_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    chk("fresh_ack_drop", {31'd0, bus.wb_ack_o}, 32'd0);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpio_wb.md
Name: gpio_wb

Overview:
- Wishbone-slave general-purpose I/O block with N bidirectional pins.
- Sits on the SoC's shared Wishbone bus next to ROM, RAM and UART; the interconnect decodes the block's address range and drives its strobe.
- Four 32-bit word registers: pin data, output enable, bit-set and bit-clear.

Parameters:
N, 32, number of GPIO pins (legal 1..32); register bits at index N and above read 0 and ignore writes.

Ports:
wb_clk_i  input  1  clock; all state updates on its rising edge
wb_rst_i  input  1  reset, asynchronous, active-low (0 = reset)
wb_adr_i  input  2  word address (bus address bits [3:2])
wb_dat_i  input  32  write data
wb_dat_o  output  32  read data, registered
wb_we_i  input  1  1 = write, 0 = read
wb_sel_i  input  4  byte enables; bit k covers data bits [8k+7:8k]
wb_stb_i  input  1  transfer request (cycle qualification done by interconnect)
wb_ack_o  output  1  transfer acknowledge, one-cycle pulse
gpio_io  inout  N  pins

Behaviour:
- Internal state:
  - out[N-1:0]: output latch.
  - oe[N-1:0]: output enable, 1 = drive.
  - sync1/sync2[N-1:0]: 2-flop input synchronizer.
  - ack flop.
  - dat_o register.
- Reset (wb_rst_i=0, asynchronous): out=0, oe=0 (all pins hi-Z), sync1=sync2=0, wb_ack_o=0, wb_dat_o=0.
- Pin drive: gpio_io[i] = oe[i] ? out[i] : Z, continuous and combinational from the registers.
- Synchronizer runs every cycle: sync1<=gpio_io; sync2<=sync1.
- Handshake:
  - On a rising edge with wb_stb_i=1 and wb_ack_o=0: perform the access and set wb_ack_o=1.
  - On the next edge wb_ack_o returns to 0 unconditionally.
  - Latency is exactly one cycle.
  - A strobe held high yields an ack every second cycle; each ack completes one access.
  - No access occurs while wb_ack_o=1.
- Register map (wb_adr_i):
  - 0 DATA. Read returns sync2 (pin levels). Write loads out from wb_dat_i, per selected byte.
  - 1 OE. Read returns oe. Write loads oe, per selected byte.
  - 2 SET. Read returns out. Write: out |= wb_dat_i, masked to selected bytes.
  - 3 CLR. Read returns out. Write: out &= ~wb_dat_i, masked to selected bytes.
- Byte enables: only bits within bytes whose wb_sel_i bit is 1 may change. wb_sel_i=0 on a write is still acked and changes nothing.
- Read data:
  - Captured into wb_dat_o on the access edge.
  - Zero-extended above bit N-1.
  - Holds its value until the next read access; writes leave wb_dat_o unchanged.
- Input timing:
  - A pin change present before edge k appears in sync2 after edge k+1.
  - A DATA read accessed at edge k+2 or later returns the new value.
- Output pins read back through DATA after the same two-flop delay (pad loopback).
- Reset asserted mid-transfer: ack and state clear immediately. After release, a still-high strobe starts a fresh access on the next edge.

Test Plan:
- Reset: hold wb_rst_i=0, then release → wb_ack_o=0, wb_dat_o=0; gpio_io all Z; reads of OE and SET return 0x00000000, each acked exactly one cycle after stb.
- Drive: write OE=0x000000FF, then DATA=0x000000A5 with sel=4'hF → gpio_io[7:0]=0xA5 and [31:8] Z; DATA read ≥2 cycles later returns 0x000000A5 (upper bits from external pulls, tie 0 in bench).
- Set/clear: from out=0x000000A5, write SET=0x0000000A → out=0x000000AF; write CLR=0x000000A0 → out=0x0000000F; read SET returns 0x0000000F.
- Byte select: OE=0xFFFFFFFF, out=0; write DATA=0x11223344 with sel=4'b0101 → out=0x00220044 on pins and via SET read.
- Input sync: OE=0, bench drives gpio_io=0xDEADBEEF just before edge k; DATA read accessed at edge k+1 returns old value; access at edge k+2 returns 0xDEADBEEF.
- Ack pulse: hold wb_stb_i=1 with we=0 for 6 cycles → wb_ack_o pattern 0,1,0,1,0,1 (three reads); assert reset during an ack → ack drops asynchronously.
